ccd_cds_sampler: RTL



---
 rtl/ccd_cds_sampler_if.sv | 21 ++
 rtl/ccd_cds_sampler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ccd_cds_sampler_if.sv
// Wishbone slave bundle between the Caravel management core and the CDS sampler.
interface ccd_cds_sampler_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/ccd_cds_sampler.sv
// Correlated double sampler: times reference/signal ADC conversions off the CCD phases,
// stores clamped (ref - sig) pixels tagged with the line count in a FIFO drained over Wishbone.
// states: IDLE wait phi_r fall | WAIT_REF/WAIT_SIG delay | CONV_REF/CONV_SIG await adc_done | ARM_SIG wait phi_l2 fall | STORE push
module ccd_cds_sampler #(
    parameter int          ADC_WIDTH      = 12,
    parameter int          REF_DELAY      = 4,
    parameter int          SIG_DELAY      = 4,
    parameter int          FIFO_DEPTH     = 16,
    parameter logic [31:0] CTRL_ADDRESS   = 32'h3000_0020,
    parameter logic [31:0] STATUS_ADDRESS = 32'h3000_0024,
    parameter logic [31:0] DATA_ADDRESS   = 32'h3000_0028,
    parameter logic [31:0] LINE_ADDRESS   = 32'h3000_002C
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    ccd_cds_sampler_if.slave     wbs,
    input  logic                 phi_p_i,
    input  logic                 phi_l2_i,
    input  logic                 phi_r_i,
    output logic                 adc_start_o,
    input  logic                 adc_done_i,
    input  logic [ADC_WIDTH-1:0] adc_data_i
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 16 + ADC_WIDTH;
    localparam int CW = 8;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_REF = 3'd1;
    localparam logic [2:0] S_CONV_REF = 3'd2;
    localparam logic [2:0] S_ARM_SIG  = 3'd3;
    localparam logic [2:0] S_WAIT_SIG = 3'd4;
    localparam logic [2:0] S_CONV_SIG = 3'd5;
    localparam logic [2:0] S_STORE    = 3'd6;

    logic [2:0]           r_sync_r, r_sync_l2, r_sync_p;
    logic [2:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic                 r_adc_start;
    logic [ADC_WIDTH-1:0] r_ref, r_sig;
    logic                 r_enable, r_overflow, r_missed;
    logic [15:0]          r_line_cnt;
    logic [EW-1:0]        r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]        r_level;
    logic                 r_ack;
    logic [31:0]          r_dat;

    logic                 w_r_fall, w_l2_fall, w_p_rise, w_fsm_run;
    logic                 w_sel_ctrl, w_sel_status, w_sel_data, w_sel_line, w_hit;
    logic                 w_req, w_wr, w_rd, w_clear;
    logic                 w_full, w_empty, w_push, w_push_ok, w_pop;
    logic [ADC_WIDTH-1:0] w_pixel;
    logic [31:0]          w_rd_data;
    logic                 w_unused;

    // Sync chains run through reset so no false edge appears when reset is released.
    always_ff @(posedge wb_clk_i) begin
        r_sync_r  <= {r_sync_r[1:0],  phi_r_i};
        r_sync_l2 <= {r_sync_l2[1:0], phi_l2_i};
        r_sync_p  <= {r_sync_p[1:0],  phi_p_i};
    end

    assign w_r_fall  = r_sync_r[2]  & ~r_sync_r[1];
    assign w_l2_fall = r_sync_l2[2] & ~r_sync_l2[1];
    assign w_p_rise  = ~r_sync_p[2] &  r_sync_p[1];
    assign w_fsm_run = r_enable & ~w_p_rise;

    assign w_sel_ctrl   = (wbs.wbs_adr_i == CTRL_ADDRESS);
    assign w_sel_status = (wbs.wbs_adr_i == STATUS_ADDRESS);
    assign w_sel_data   = (wbs.wbs_adr_i == DATA_ADDRESS);
    assign w_sel_line   = (wbs.wbs_adr_i == LINE_ADDRESS);
    assign w_hit   = w_sel_ctrl | w_sel_status | w_sel_data | w_sel_line;
    assign w_req   = wbs.wbs_stb_i & wbs.wbs_cyc_i & w_hit & ~r_ack;
    assign w_wr    = w_req & wbs.wbs_we_i;
    assign w_rd    = w_req & ~wbs.wbs_we_i;
    assign w_clear = w_wr & w_sel_ctrl & wbs.wbs_dat_i[1];

    assign w_full    = (r_level == LW'(FIFO_DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_pop     = w_rd & w_sel_data & ~w_empty;
    assign w_push    = w_fsm_run & (r_state == S_STORE) & ~w_clear;
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_pixel   = (r_ref >= r_sig) ? (r_ref - r_sig) : '0;
    assign w_unused  = ^{wbs.wbs_sel_i, wbs.wbs_dat_i[31:2]};

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_adc_start <= 1'b0;
            r_ref       <= '0;
            r_sig       <= '0;
        end else begin
            r_adc_start <= 1'b0;
            if (!w_fsm_run) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: if (w_r_fall) begin
                        r_state <= S_WAIT_REF;
                        r_cnt   <= CW'(REF_DELAY);
                    end
                    S_WAIT_REF: if (r_cnt <= CW'(1)) begin
                        r_state     <= S_CONV_REF;
                        r_cnt       <= '0;
                        r_adc_start <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                    S_CONV_REF: if (adc_done_i) begin
                        r_ref   <= adc_data_i;
                        r_state <= S_ARM_SIG;
                    end
                    S_ARM_SIG: if (w_l2_fall) begin
                        r_state <= S_WAIT_SIG;
                        r_cnt   <= CW'(SIG_DELAY);
                    end
                    S_WAIT_SIG: if (r_cnt <= CW'(1)) begin
                        r_state     <= S_CONV_SIG;
                        r_cnt       <= '0;
                        r_adc_start <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                    S_CONV_SIG: if (adc_done_i) begin
                        r_sig   <= adc_data_i;
                        r_state <= S_STORE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_line_cnt <= '0;
            r_overflow <= 1'b0;
            r_missed   <= 1'b0;
        end else if (w_clear) begin
            r_line_cnt <= '0;
            r_overflow <= 1'b0;
            r_missed   <= 1'b0;
        end else begin
            if (w_p_rise)
                r_line_cnt <= r_line_cnt + 1'b1;
            if (w_push & ~w_push_ok)
                r_overflow <= 1'b1;
            if (w_r_fall & ~w_p_rise & (r_state != S_IDLE) & (r_state != S_STORE))
                r_missed <= 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + LW'(w_push_ok) - LW'(w_pop);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= {r_line_cnt, w_pixel};
    end

    always_comb begin
        w_rd_data = '0;
        if (w_sel_ctrl)
            w_rd_data = {31'b0, r_enable};
        else if (w_sel_status)
            w_rd_data = {20'b0, r_missed, r_overflow, w_full, w_empty, 8'(r_level)};
        else if (w_sel_data)
            w_rd_data = w_empty ? '0 : 32'(r_mem[r_rd_ptr]);
        else if (w_sel_line)
            w_rd_data = {16'b0, r_line_cnt};
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_enable <= 1'b0;
        end else begin
            r_ack <= w_req;
            r_dat <= w_rd ? w_rd_data : '0;
            if (w_wr & w_sel_ctrl)
                r_enable <= wbs.wbs_dat_i[0];
        end
    end

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat;
    assign adc_start_o   = r_adc_start;
endmodule
